pc_sequencer: RTL

- Registered program-counter sequencer; the parametrised successor of the combinational next-address mux.
- Each accepted fetch cycle selects the next PC from one of these sources:
  - PC+1 (sequential)
  - conditional relative branch
  - absolute jump from Bus_A
  - call/return through an internal return-address stack (RAS)
- Sits between the control decoder / flag logic and the instruction-memory address port.

---
 rtl/pc_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Registered program-counter sequencer. On each accepted fetch cycle
//   (advance=1) the next PC comes from PC+1, a conditional relative branch,
//   an absolute jump from Bus_A, or a call/return through an internal
//   circular return-address stack (RAS).
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   advance    in   fetch accepted; PC/RAS update only when set
//   mode       in   [2:0] next-address mode (SEQ/BRT/BRF/JMP/CALL/RET)
//   cond       in   branch condition
//   Bus_A      in   [AW-1:0] absolute jump/call target
//   offset     in   [AW-1:0] sign-extended relative displacement
//   pc         out  [AW-1:0] current PC (registered)
//   redirect   out  registered; 1 after a non-sequential PC load
//   ras_count  out  number of valid RAS entries
//   trap       out  registered stack-fault pulse
//
// Optional feature macro: RAS_FAULT_TRAP_EN
//   Defined   : CALL on a full stack or RET on an empty stack loads TRAP_VEC
//               and pulses trap/redirect; stack state is left untouched.
//   Undefined : CALL on full overwrites the oldest entry, RET on empty acts
//               as SEQ; trap is constant 0.
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned    AW       = 32,
    parameter int unsigned    DEPTH    = 4,
    parameter logic [AW-1:0]  RESET_PC = '0,
    parameter logic [AW-1:0]  TRAP_VEC = 32'hFFFF_FFF0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        advance,
    input  logic [2:0]                  mode,
    input  logic                        cond,
    input  logic [AW-1:0]               Bus_A,
    input  logic [AW-1:0]               offset,
    output logic [AW-1:0]               pc,
    output logic                        redirect,
    output logic [$clog2(DEPTH+1)-1:0]  ras_count,
    output logic                        trap
);

    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] MODE_SEQ  = 3'b000;
    localparam logic [2:0] MODE_BRT  = 3'b001;
    localparam logic [2:0] MODE_BRF  = 3'b010;
    localparam logic [2:0] MODE_JMP  = 3'b011;
    localparam logic [2:0] MODE_CALL = 3'b100;
    localparam logic [2:0] MODE_RET  = 3'b101;

    localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);
    localparam logic [PTRW-1:0] PTR_LAST = PTRW'(DEPTH - 1);

    logic [AW-1:0]   pc_q, pc_d;
    logic            redirect_q, redirect_d;
    logic            trap_q, trap_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PTRW-1:0] top_q, top_d;
    logic [AW-1:0]   ras_q [DEPTH];

    logic            push;
    logic [AW-1:0]   pc_inc;
    logic [AW-1:0]   pc_rel;
    logic [PTRW-1:0] top_inc;
    logic [PTRW-1:0] top_dec;
    logic            ras_full;
    logic            ras_empty;

    assign pc_inc    = pc_q + 1'b1;
    assign pc_rel    = pc_q + offset;
    assign top_inc   = (top_q == PTR_LAST) ? '0 : top_q + 1'b1;
    assign top_dec   = (top_q == '0) ? PTR_LAST : top_q - 1'b1;
    assign ras_full  = (cnt_q == CNT_FULL);
    assign ras_empty = (cnt_q == '0);

`ifndef RAS_FAULT_TRAP_EN
    logic [AW-1:0] unused_trap_vec;
    assign unused_trap_vec = TRAP_VEC;
`endif

    always_comb begin
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        top_d      = top_q;
        redirect_d = 1'b0;
        trap_d     = 1'b0;
        push       = 1'b0;

        if (advance) begin
            case (mode)
                MODE_BRT: begin
                    if (cond) begin
                        pc_d       = pc_rel;
                        redirect_d = 1'b1;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
                MODE_BRF: begin
                    if (!cond) begin
                        pc_d       = pc_rel;
                        redirect_d = 1'b1;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
                MODE_JMP: begin
                    pc_d       = Bus_A;
                    redirect_d = 1'b1;
                end
                MODE_CALL: begin
`ifdef RAS_FAULT_TRAP_EN
                    if (ras_full) begin
                        pc_d       = TRAP_VEC;
                        trap_d     = 1'b1;
                        redirect_d = 1'b1;
                    end else begin
                        push       = 1'b1;
                        top_d      = top_inc;
                        cnt_d      = cnt_q + 1'b1;
                        pc_d       = Bus_A;
                        redirect_d = 1'b1;
                    end
`else
                    // Circular storage: a push on a full stack lands on the
                    // oldest slot, so the count simply saturates.
                    push       = 1'b1;
                    top_d      = top_inc;
                    pc_d       = Bus_A;
                    redirect_d = 1'b1;
                    if (!ras_full) begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
                MODE_RET: begin
                    if (ras_empty) begin
`ifdef RAS_FAULT_TRAP_EN
                        pc_d       = TRAP_VEC;
                        trap_d     = 1'b1;
                        redirect_d = 1'b1;
`else
                        pc_d = pc_inc;
`endif
                    end else begin
                        pc_d       = ras_q[top_q];
                        top_d      = top_dec;
                        cnt_d      = cnt_q - 1'b1;
                        redirect_d = 1'b1;
                    end
                end
                default: begin
                    pc_d = pc_inc;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
            trap_q     <= 1'b0;
            cnt_q      <= '0;
            top_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            trap_q     <= trap_d;
            cnt_q      <= cnt_d;
            top_q      <= top_d;
        end
    end

    // Stack storage needs no reset; entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            ras_q[top_inc] <= pc_inc;
        end
    end

    assign pc        = pc_q;
    assign redirect  = redirect_q;
    assign ras_count = cnt_q;
    assign trap      = trap_q;

endmodule
